uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter and drives its din/din_vld inputs.
- Absorbs bursts of bytes from the host side into a FIFO.
- Issues one byte at a time to the transmitter, using the transmitter's rfd (ready-for-data) handshake.
- If the transmitter never takes a byte, the same byte is re-issued after a timeout. Overflow is reported on a sticky flag.

Parameters:
- DATA_WIDTH, 8, byte width; must equal the transmitter DI_WIDTH.
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- AFULL_THRESH, 12, almost_full asserts when level >= AFULL_THRESH.
- ACK_TIMEOUT, 4096, clk cycles to wait for rfd to fall after a din_vld pulse before re-issuing the byte.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset.
- wr_data, in, DATA_WIDTH, host byte to enqueue.
- wr_en, in, 1, enqueue strobe, sampled each clk.
- flush, in, 1, synchronous clear of the FIFO and the FSM.
- clr_err, in, 1, clears ovf_err.
- full, out, 1, FIFO full.
- almost_full, out, 1, level >= AFULL_THRESH.
- empty, out, 1, FIFO empty.
- level, out, $clog2(DEPTH)+1, number of stored entries (excludes the held byte).
- ovf_err, out, 1, sticky: a write was dropped because the FIFO was full.
- din, out, DATA_WIDTH, byte presented to the transmitter.
- din_vld, out, 1, one-cycle issue pulse to the transmitter.
- rfd, in, 1, transmitter ready for data.

Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst. All outputs are registered.

Behaviour:
- Reset: pointers=0, level=0, empty=1, full=0, almost_full=0, ovf_err=0, din=0, din_vld=0, FSM=IDLE, timer=0.
- FIFO write:
  - wr_en && !full && !flush stores wr_data at wr_ptr; wr_ptr wraps modulo DEPTH.
  - full is the registered value at the start of the cycle. A write while full is dropped and sets ovf_err, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): level unchanged; both pointers advance.
- Pointers carry one extra wrap bit; full/empty are derived from the pointers.
- flush:
  - Next edge: pointers=0, level=0, FSM=IDLE, din_vld=0, held byte discarded.
  - A same-cycle wr_en is dropped without setting ovf_err.
  - flush has priority over all other events except rst.
- ovf_err: set on a dropped write; cleared by clr_err. Set wins if both occur in the same cycle.
- FSM states:
  - IDLE: if !empty && rfd, pop mem[rd_ptr] into din, set din_vld=1, go to ISSUE. Otherwise hold; din keeps its last value.
  - ISSUE: din_vld=0 (so the pulse lasts exactly one cycle), timer=0, go to WAIT_ACK.
  - WAIT_ACK: if !rfd, go to WAIT_RDY (byte accepted). Else timer+1; when timer==ACK_TIMEOUT-1, set din_vld=1 with the same din and go to ISSUE (re-issue; no pop).
  - WAIT_RDY: when rfd=1, go to IDLE.
- Latency: from a write into an empty FIFO with rfd=1 (write at edge N), din_vld is high during the cycle after edge N+1.
- Throughput: one byte per transmitter frame; back-to-back bytes need at least 4 clk between din_vld pulses.
- rfd low in IDLE: no issue; the FIFO keeps accepting writes.
- level must never exceed DEPTH. Wrap-around occurs at DEPTH-1 -> 0 on both pointers.
- Reset mid-operation (any state) returns to the reset values immediately (asynchronous). A byte currently being transmitted by the UART is not recalled.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT_ACK, WAIT_RDY).
  - Default DATA_WIDTH constant.
  - Function for level width, clog2(DEPTH)+1.
- One natural sub-module: uart_sync_fifo.
  - Contains memory, pointers, level, full/empty/almost_full and overflow detection.
  - Top level holds the issue FSM, timeout counter and ovf_err.

Test Plan:
- Reset, then write 0xA5 with rfd=1 → din=0xA5; din_vld high for exactly 1 cycle, 2 edges after the write; empty=1 afterwards. Drop rfd for 10 clk then raise → FSM returns to IDLE with no further pulse.
- Hold rfd=0 and write 16 bytes 0x00..0x0F → full=1, almost_full=1 from level 12, level=16. A 17th write (0xFF) → dropped, ovf_err=1. clr_err → ovf_err=0.
- Then model the transmitter (rfd falls 2 clk after each din_vld, rises 100 clk later) → din sequence 0x00..0x0F in order, empty=1 at end, no duplicates.
- With rfd held at 1 permanently after one write of 0x3C, ACK_TIMEOUT=16 → din_vld re-pulses with din=0x3C every 17 clk; level stays 0.
- Fill 5 bytes, assert flush together with wr_en (0x77) → level=0, empty=1, ovf_err=0, no din_vld. A following write of 0x11 issues 0x11.
- Assert rst while in WAIT_ACK with level=3 → all outputs at reset values in the same cycle. After release, no din_vld until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, default byte width and level-width helper for the tx feeder.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_RDY} state_t;
    localparam int DEF_DATA_WIDTH = 8;
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with wrap-bit pointers, registered flags and overflow strobe.
module uart_sync_fifo import uart_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic                          ovf,
    output logic [lvl_width(DEPTH)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr, r_level, w_wr_ptr, w_rd_ptr, w_level;
    logic r_full, r_empty, r_afull, w_push, w_pop;
    assign w_push = push && !r_full && !flush;
    assign w_pop  = pop && !r_empty && !flush;
    assign ovf    = push && r_full && !flush;
    always_comb begin
        w_wr_ptr = flush ? '0 : r_wr_ptr + LW'(w_push);
        w_rd_ptr = flush ? '0 : r_rd_ptr + LW'(w_pop);
        w_level  = w_wr_ptr - w_rd_ptr;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr;
            r_rd_ptr <= w_rd_ptr;
            r_level  <= w_level;
            r_full   <= (w_wr_ptr[AW] != w_rd_ptr[AW]) && (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]);
            r_empty  <= w_wr_ptr == w_rd_ptr;
            r_afull  <= w_level >= LW'(AFULL_THRESH);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
    assign rd_data     = r_mem[r_rd_ptr[AW-1:0]];
    assign full        = r_full;
    assign empty       = r_empty;
    assign almost_full = r_afull;
    assign level       = r_level;
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and issues them one at a time to a UART transmitter via rfd handshake.
module uart_tx_feeder import uart_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12,
    parameter int ACK_TIMEOUT  = 4096
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic [lvl_width(DEPTH)-1:0]   level,
    output logic                          ovf_err,
    output logic [DATA_WIDTH-1:0]         din,
    output logic                          din_vld,
    input  logic                          rfd
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    state_t r_state, w_state;
    logic [TW-1:0] r_timer, w_timer;
    logic [DATA_WIDTH-1:0] r_din, w_din, w_rd_data;
    logic r_din_vld, w_din_vld, r_ovf_err, w_ovf_err, w_pop, w_ovf;
    uart_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL_THRESH)
    ) u_fifo (
        .clk(clk), .rst(rst), .flush(flush), .push(wr_en), .pop(w_pop),
        .wr_data(wr_data), .rd_data(w_rd_data), .full(full),
        .almost_full(almost_full), .empty(empty), .ovf(w_ovf), .level(level)
    );
    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_din     = r_din;
        w_din_vld = 1'b0;
        w_pop     = 1'b0;
        w_ovf_err = w_ovf ? 1'b1 : clr_err ? 1'b0 : r_ovf_err;
        if (flush) begin
            w_state = IDLE;
            w_timer = '0;
        end else begin
            case (r_state)
                IDLE: if (!empty && rfd) begin
                    w_pop     = 1'b1;
                    w_din     = w_rd_data;
                    w_din_vld = 1'b1;
                    w_state   = ISSUE;
                end
                ISSUE: begin
                    w_timer = '0;
                    w_state = WAIT_ACK;
                end
                // rfd staying high means the transmitter never took the byte; re-pulse it after the timeout
                WAIT_ACK: if (!rfd) w_state = WAIT_RDY;
                    else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                        w_din_vld = 1'b1;
                        w_state   = ISSUE;
                    end else w_timer = r_timer + TW'(1);
                WAIT_RDY: if (rfd) w_state = IDLE;
                default: w_state = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_din     <= '0;
            r_din_vld <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_din     <= w_din;
            r_din_vld <= w_din_vld;
            r_ovf_err <= w_ovf_err;
        end
    end
    assign din     = r_din;
    assign din_vld = r_din_vld;
    assign ovf_err = r_ovf_err;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_uart_tx_feeder;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AF = 12;
    localparam int TO = 16;
    localparam logic [17:0] RST_VEC = 18'h01000;
    logic clk = 0, rst = 0, wr_en = 0, flush = 0, clr_err = 0, rfd = 0;
    logic [DW-1:0] wr_data = '0, din;
    logic full, almost_full, empty, ovf_err, din_vld;
    logic [4:0] level;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush), .clr_err(clr_err),
        .full(full), .almost_full(almost_full), .empty(empty), .level(level), .ovf_err(ovf_err),
        .din(din), .din_vld(din_vld), .rfd(rfd)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1;
        #2;
        checks++; if ({level, empty, full, almost_full, ovf_err, din, din_vld} !== RST_VEC) begin errors++; $display("FAIL reset_async got=%h exp=%h", {level, empty, full, almost_full, ovf_err, din, din_vld}, RST_VEC); end
        tick;
        rst = 0;
        tick;
        checks++; if ({level, empty, full, almost_full, ovf_err, din, din_vld} !== RST_VEC) begin errors++; $display("FAIL reset_hold got=%h exp=%h", {level, empty, full, almost_full, ovf_err, din, din_vld}, RST_VEC); end
    endtask

    task automatic test_single;
        int seen = 0;
        rfd = 1; wr_en = 1; wr_data = 8'hA5;
        tick;
        wr_en = 0;
        checks++; if (din_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld got=%b exp=0", din_vld); end
        tick;
        checks++; if (din_vld !== 1'b1) begin errors++; $display("FAIL single_vld got=%b exp=1", din_vld); end
        checks++; if (din !== 8'hA5) begin errors++; $display("FAIL single_din got=%h exp=a5", din); end
        tick;
        checks++; if (din_vld !== 1'b0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", din_vld); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
        rfd = 0;
        repeat (10) begin tick; if (din_vld) seen++; end
        rfd = 1;
        repeat (10) begin tick; if (din_vld) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL single_no_repulse got=%0d exp=0", seen); end
    endtask

    task automatic test_fill_ovf;
        rfd = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_data = 8'(i);
            tick;
            checks++; if (level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
            checks++; if (almost_full !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, i + 1 >= AF); end
            checks++; if (full !== (i + 1 == DEPTH)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i + 1 == DEPTH); end
        end
        wr_data = 8'hFF;
        tick;
        wr_en = 0;
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", level); end
        clr_err = 1;
        tick;
        clr_err = 0;
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_err); end
    endtask

    task automatic test_drain;
        logic [7:0] got[$];
        int last = -100, low_at = -1, high_at = -1;
        rfd = 1;
        for (int c = 0; c < 2500 && !(got.size() == DEPTH && c > last + 150); c++) begin
            tick;
            if (din_vld) begin
                got.push_back(din);
                checks++; if (c - last < 4) begin errors++; $display("FAIL drain_gap got=%0d exp>=4", c - last); end
                last = c; low_at = c + 1;
            end
            if (c == low_at) begin rfd = 0; high_at = c + 100; end
            if (c == high_at) rfd = 1;
        end
        checks++; if (got.size() !== DEPTH) begin errors++; $display("FAIL drain_count got=%0d exp=%0d", got.size(), DEPTH); end
        for (int i = 0; i < got.size() && i < DEPTH; i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, got[i], 8'(i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_timeout;
        int pulses[$];
        rfd = 1; wr_en = 1; wr_data = 8'h3C;
        tick;
        wr_en = 0;
        for (int c = 1; c <= 60; c++) begin
            tick;
            if (din_vld) begin
                pulses.push_back(c);
                checks++; if (din !== 8'h3C) begin errors++; $display("FAIL timeout_din got=%h exp=3c", din); end
            end
            checks++; if (level !== 5'd0) begin errors++; $display("FAIL timeout_level got=%0d exp=0", level); end
        end
        checks++; if (pulses.size() !== 4) begin errors++; $display("FAIL timeout_count got=%0d exp=4", pulses.size()); end
        for (int k = 0; k < pulses.size() && k < 4; k++) begin
            checks++; if (pulses[k] !== 1 + (TO + 1) * k) begin errors++; $display("FAIL timeout_cycle[%0d] got=%0d exp=%0d", k, pulses[k], 1 + (TO + 1) * k); end
        end
        rfd = 0;
    endtask

    task automatic test_flush;
        int seen = 0;
        flush = 1;
        tick;
        flush = 0;
        for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = 8'(8'h50 + i); tick; end
        wr_en = 0;
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        flush = 1; wr_en = 1; wr_data = 8'h77;
        tick;
        flush = 0; wr_en = 0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", ovf_err); end
        rfd = 1;
        repeat (5) begin tick; if (din_vld) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_issue got=%0d exp=0", seen); end
        wr_en = 1; wr_data = 8'h11;
        tick;
        wr_en = 0;
        tick;
        checks++; if (din_vld !== 1'b1) begin errors++; $display("FAIL flush_after_vld got=%b exp=1", din_vld); end
        checks++; if (din !== 8'h11) begin errors++; $display("FAIL flush_after_din got=%h exp=11", din); end
    endtask

    task automatic test_rst_mid;
        int n = 0, seen = 0;
        tick;
        rfd = 0;
        for (int i = 0; i < 4; i++) begin wr_en = 1; wr_data = 8'(8'hC0 + i); tick; end
        wr_en = 0; rfd = 1;
        do begin tick; n++; end while (!din_vld && n < 20);
        checks++; if (din_vld !== 1'b1) begin errors++; $display("FAIL rstmid_issue got=%b exp=1", din_vld); end
        tick;
        tick;
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL rstmid_level got=%0d exp=3", level); end
        #2 rst = 1;
        #1;
        checks++; if ({level, empty, full, almost_full, ovf_err, din, din_vld} !== RST_VEC) begin errors++; $display("FAIL rstmid_async got=%h exp=%h", {level, empty, full, almost_full, ovf_err, din, din_vld}, RST_VEC); end
        tick;
        rst = 0;
        repeat (20) begin tick; if (din_vld) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_issue got=%0d exp=0", seen); end
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        logic exp_ovf = 0, pre_rfd, pre_wr, pre_clr;
        logic [7:0] pre_d;
        int pre, last = -100, rise = 0;
        bit fall = 0;
        rfd = 1;
        for (int c = 0; c < 1200; c++) begin
            wr_en = (c < 500) && ($urandom_range(0, 99) < 45);
            wr_data = 8'($urandom);
            clr_err = ($urandom_range(0, 29) == 0);
            pre = q.size(); pre_rfd = rfd; pre_wr = wr_en; pre_d = wr_data; pre_clr = clr_err;
            tick;
            if (din_vld) begin
                checks++; if (!(pre > 0 && pre_rfd)) begin errors++; $display("FAIL rnd_issue_legal got=1 exp=0 size=%0d rfd=%b", pre, pre_rfd); end
                if (pre > 0) begin
                    checks++; if (din !== q[0]) begin errors++; $display("FAIL rnd_din got=%h exp=%h", din, q[0]); end
                    void'(q.pop_front());
                end
                checks++; if (c - last < 4) begin errors++; $display("FAIL rnd_gap got=%0d exp>=4", c - last); end
                last = c; fall = 1;
            end else if (fall) begin
                fall = 0; rfd = 0; rise = $urandom_range(3, 30);
            end else if (rise > 0) begin
                rise--;
                if (rise == 0) rfd = 1;
            end
            if (pre_wr && pre < DEPTH) q.push_back(pre_d);
            exp_ovf = (pre_wr && pre == DEPTH) ? 1'b1 : pre_clr ? 1'b0 : exp_ovf;
            checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q.size()); end
            checks++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, empty, q.size() == 0); end
            checks++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full, q.size() == DEPTH); end
            checks++; if (almost_full !== (q.size() >= AF)) begin errors++; $display("FAIL rnd_afull c=%0d got=%b exp=%b", c, almost_full, q.size() >= AF); end
            checks++; if (ovf_err !== exp_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, ovf_err, exp_ovf); end
        end
        wr_en = 0; clr_err = 0;
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rnd_drained got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill_ovf;
        test_drain;
        test_timeout;
        test_flush;
        test_rst_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
